// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions.
// State encoding and framing constants for the boot loader.
package imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_RECV  = 3'd1;
    localparam state_t S_WRITE = 3'd2;
    localparam state_t S_CHK   = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    localparam int   BYTES_PER_WORD   = 4;
    localparam logic CPU_RESET_ACTIVE = 1'b1;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader bus: control, byte stream, iram write port, status.
// master drives the stream and start; slave is the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH:0]   word_count;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, busy, done, error
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, busy, done, error
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer with running XOR checksum.
// word_full_o strobes on the byte that completes a word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [7:0]  acc_o,
    output logic        word_full_o
);
    logic [23:0] word_q;
    logic [1:0]  cnt_q;
    logic [7:0]  acc_q;

    // Shift bytes in MSB-first, count them and fold into the checksum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else if (shift_i) begin
            word_q <= {word_q[15:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
            acc_q  <= acc_q ^ byte_i;
        end
    end

    assign word_o      = {word_q, byte_i};
    assign acc_o       = acc_q;
    assign word_full_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM loader with XOR checksum check.
// Holds the core in reset until a clean load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic          clock,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic                  cpurst_q;

    logic        ready;
    logic        xfer;
    logic        start_ok;
    logic        ovf;
    logic        last;
    logic        shift;
    logic        full;
    logic [31:0] word;
    logic [7:0]  acc;

    assign xfer     = bus.byte_valid && ready;
    assign start_ok = bus.start
                   && (state_q == S_IDLE || state_q == S_DONE);
    assign ovf      = bus.word_count > DEPTH;
    assign last     = ({1'b0, idx_q} == cnt_q - 1'b1);
    assign shift    = xfer && (state_q == S_RECV);

    imem_loader_byte_packer u_packer (
        .clk_i       (clock),
        .rst_ni      (reset),
        .clr_i       (start_ok),
        .shift_i     (shift),
        .byte_i      (bus.byte_in),
        .word_o      (word),
        .acc_o       (acc),
        .word_full_o (full)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: start, per-word receive/write loop, checksum.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    if (ovf)                   state_d = S_DONE;
                    else if (bus.word_count == '0) state_d = S_CHK;
                    else                       state_d = S_RECV;
                end
            end
            S_RECV:  if (full) state_d = S_WRITE;
            S_WRITE: state_d = last ? S_CHK : S_RECV;
            S_CHK:   if (xfer) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        ready       = (state_q == S_RECV) || (state_q == S_CHK);
        bus.busy    = (state_q == S_RECV) || (state_q == S_WRITE)
                   || (state_q == S_CHK);
        bus.done    = (state_q == S_DONE);
        bus.imem_we = (state_q == S_WRITE);
    end

    // Count, index, write-port and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            cpurst_q <= CPU_RESET_ACTIVE;
        end else if (start_ok) begin
            cnt_q    <= bus.word_count;
            idx_q    <= '0;
            err_q    <= ovf;
            cpurst_q <= CPU_RESET_ACTIVE;
        end else begin
            if (full) begin
                addr_q  <= idx_q;
                wdata_q <= DATA_WIDTH'(word);
            end
            if (state_q == S_WRITE && !last) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == S_CHK && xfer) begin
                err_q    <= (bus.byte_in != acc);
                cpurst_q <= (bus.byte_in != acc);
            end
        end
    end

    assign bus.byte_ready = ready;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.error      = err_q;
    assign bus.cpu_reset  = cpurst_q;

endmodule
